// File: rtl/ip_rewrite_table_wr_pkg.sv
// Shared types for the IP-rewrite flow-table writer: FSM states, config/ack flit layouts,
// table entry format and the noc0 message types it speaks.
package ip_rewrite_table_wr_pkg;

  localparam logic [7:0] NOC_MSG_NOP                = 8'h00;
  localparam logic [7:0] NOC_MSG_DATA               = 8'h01;
  localparam logic [7:0] NOC_MSG_IP_REWRITE_CFG     = 8'h20;
  localparam logic [7:0] NOC_MSG_IP_REWRITE_CFG_ACK = 8'h21;

  typedef enum logic [2:0] {
    ST_READY    = 3'd0,
    ST_CFG      = 3'd1,
    ST_WR_TABLE = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_ACK_HDR  = 3'd4,
    ST_ACK_BODY = 3'd5
  } state_e;

  typedef enum logic [7:0] {
    CFG_OP_WRITE = 8'h01,
    CFG_OP_CLEAR = 8'h02
  } cfg_op_e;

  typedef enum logic [7:0] {
    CFG_OK      = 8'd0,
    CFG_BAD_OP  = 8'd1,
    CFG_BAD_IDX = 8'd2,
    CFG_BAD_LEN = 8'd3
  } cfg_status_e;

  // Header occupies the top bits of every noc0 header flit.
  typedef struct packed {
    logic [7:0] dst_x;
    logic [7:0] dst_y;
    logic [7:0] src_x;
    logic [7:0] src_y;
    logic [7:0] msg_len;
    logic [7:0] msg_type;
  } noc_hdr_flit_s;

  // Opcode kept as raw bits: illegal values arrive on the wire and must be reported.
  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] tag;
    logic [15:0] index;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [31:0] rewrite_ip;
  } ip_rewrite_cfg_flit_s;

  typedef struct packed {
    logic        valid;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [31:0] rewrite_ip;
  } ip_rewrite_entry_s;

  typedef struct packed {
    logic [15:0] tag;
    cfg_status_e status;
    logic [15:0] index;
  } ip_rewrite_cfg_ack_s;

  function automatic cfg_status_e cfg_check(input logic [7:0] op, input logic [15:0] index,
                                            input int depth);
    if (op != CFG_OP_WRITE && op != CFG_OP_CLEAR) return CFG_BAD_OP;
    if (int'(index) >= depth) return CFG_BAD_IDX;
    return CFG_OK;
  endfunction

endpackage

// File: rtl/ip_rewrite_table_wr_datap.sv
// Datapath for the flow-table writer: latched sender coords and config flit, flit countdown,
// validation status, table entry formatting, ack flit mux and the OK-ack counter.
module ip_rewrite_table_wr_datap
  import ip_rewrite_table_wr_pkg::*;
#(
  parameter int NOC_DATA_W  = 512,
  parameter int TABLE_DEPTH = 64,
  parameter int INDEX_W     = 6,
  parameter int SRC_X       = 0,
  parameter int SRC_Y       = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NOC_DATA_W-1:0] in_data,
  input  logic                  hdr_ld,
  input  logic                  cfg_ld,
  input  logic                  drain_dec,
  input  logic                  ack_body_sel,
  input  logic                  ack_done,
  output logic                  hdr_len_zero,
  output logic                  cfg_ok,
  output logic                  flits_left_one,
  output logic                  flits_left_zero,
  output logic [INDEX_W-1:0]    wr_table_index,
  output ip_rewrite_entry_s     wr_table_entry,
  output logic [NOC_DATA_W-1:0] out_data,
  output logic [31:0]           wr_done_cnt
);

  localparam int HDR_W = $bits(noc_hdr_flit_s);
  localparam int CFG_W = $bits(ip_rewrite_cfg_flit_s);
  localparam int ACK_W = $bits(ip_rewrite_cfg_ack_s);

  noc_hdr_flit_s        in_hdr;
  ip_rewrite_cfg_flit_s in_cfg;
  cfg_status_e          in_status;

  logic [7:0]           src_x_q, src_x_d;
  logic [7:0]           src_y_q, src_y_d;
  ip_rewrite_cfg_flit_s cfg_q, cfg_d;
  logic [7:0]           flits_left_q, flits_left_d;
  cfg_status_e          status_q, status_d;
  logic [31:0]          cnt_q, cnt_d;

  noc_hdr_flit_s        ack_hdr;
  ip_rewrite_cfg_ack_s  ack_body;
  logic                 unused_in_bits;

  assign in_hdr    = in_data[NOC_DATA_W-1 -: HDR_W];
  assign in_cfg    = in_data[NOC_DATA_W-1 -: CFG_W];
  assign in_status = cfg_check(in_cfg.op, in_cfg.index, TABLE_DEPTH);

  assign unused_in_bits = ^{in_data[NOC_DATA_W-CFG_W-1:0], in_hdr.dst_x, in_hdr.dst_y,
                            in_hdr.msg_type};

  assign hdr_len_zero    = (in_hdr.msg_len == 8'd0);
  assign cfg_ok          = (in_status == CFG_OK);
  assign flits_left_one  = (flits_left_q == 8'd1);
  assign flits_left_zero = (flits_left_q == 8'd0);

  always_comb begin
    src_x_d      = src_x_q;
    src_y_d      = src_y_q;
    cfg_d        = cfg_q;
    flits_left_d = flits_left_q;
    status_d     = status_q;
    cnt_d        = cnt_q;
    // Clearing the config copy on a new header makes a zero-length message ack with tag/index 0.
    if (hdr_ld) begin
      src_x_d      = in_hdr.src_x;
      src_y_d      = in_hdr.src_y;
      cfg_d        = '0;
      flits_left_d = in_hdr.msg_len;
      status_d     = hdr_len_zero ? CFG_BAD_LEN : CFG_OK;
    end
    if (cfg_ld) begin
      cfg_d        = in_cfg;
      flits_left_d = flits_left_q - 8'd1;
      status_d     = in_status;
    end
    if (drain_dec) begin
      flits_left_d = flits_left_q - 8'd1;
    end
    if (ack_done && status_q == CFG_OK) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_x_q      <= '0;
      src_y_q      <= '0;
      cfg_q        <= '0;
      flits_left_q <= '0;
      status_q     <= CFG_OK;
      cnt_q        <= '0;
    end else begin
      src_x_q      <= src_x_d;
      src_y_q      <= src_y_d;
      cfg_q        <= cfg_d;
      flits_left_q <= flits_left_d;
      status_q     <= status_d;
      cnt_q        <= cnt_d;
    end
  end

  assign wr_table_index = cfg_q.index[INDEX_W-1:0];
  assign wr_done_cnt    = cnt_q;

  always_comb begin
    wr_table_entry = '0;
    if (cfg_q.op == CFG_OP_WRITE) begin
      wr_table_entry.valid      = 1'b1;
      wr_table_entry.src_ip     = cfg_q.src_ip;
      wr_table_entry.dst_ip     = cfg_q.dst_ip;
      wr_table_entry.src_port   = cfg_q.src_port;
      wr_table_entry.dst_port   = cfg_q.dst_port;
      wr_table_entry.rewrite_ip = cfg_q.rewrite_ip;
    end
  end

  always_comb begin
    ack_hdr.dst_x    = src_x_q;
    ack_hdr.dst_y    = src_y_q;
    ack_hdr.src_x    = 8'(SRC_X);
    ack_hdr.src_y    = 8'(SRC_Y);
    ack_hdr.msg_len  = 8'd1;
    ack_hdr.msg_type = NOC_MSG_IP_REWRITE_CFG_ACK;
    ack_body.tag     = cfg_q.tag;
    ack_body.status  = status_q;
    ack_body.index   = cfg_q.index;
    out_data = '0;
    if (ack_body_sel) begin
      out_data[NOC_DATA_W-1 -: ACK_W] = ack_body;
    end else begin
      out_data[NOC_DATA_W-1 -: HDR_W] = ack_hdr;
    end
  end

endmodule

// File: rtl/ip_rewrite_table_wr_ctrl.sv
// Flow-table writer: accepts config messages on noc0, issues one table write per valid message
// and returns a 2-flit ack. Control FSM here; registers and formatting live in the datapath.
module ip_rewrite_table_wr_ctrl
  import ip_rewrite_table_wr_pkg::*;
#(
  parameter int NOC_DATA_W  = 512,
  parameter int TABLE_DEPTH = 64,
  parameter int INDEX_W     = 6,
  parameter int SRC_X       = 0,
  parameter int SRC_Y       = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  noc0_ctovr_ip_rewrite_wr_in_val,
  input  logic [NOC_DATA_W-1:0] noc0_ctovr_ip_rewrite_wr_in_data,
  output logic                  ip_rewrite_wr_in_noc0_ctovr_rdy,
  output logic                  ip_rewrite_wr_out_noc0_vrtoc_val,
  output logic [NOC_DATA_W-1:0] ip_rewrite_wr_out_noc0_vrtoc_data,
  input  logic                  noc0_vrtoc_ip_rewrite_wr_out_rdy,
  output logic                  wr_table_val,
  output logic [INDEX_W-1:0]    wr_table_index,
  output ip_rewrite_entry_s     wr_table_entry,
  input  logic                  wr_table_rdy,
  output logic [31:0]           wr_done_cnt
);

  state_e state_q, state_d;
  logic   init_done_q, init_done_d;
  logic   in_rdy, in_fire;
  logic   hdr_ld, cfg_ld, drain_dec, ack_body_sel, ack_done;
  logic   hdr_len_zero, cfg_ok, flits_left_one, flits_left_zero;

  // in_rdy is held low until the first clock after reset release.
  assign in_rdy  = init_done_q && (state_q inside {ST_READY, ST_CFG, ST_DRAIN});
  assign in_fire = noc0_ctovr_ip_rewrite_wr_in_val && in_rdy;

  assign ip_rewrite_wr_in_noc0_ctovr_rdy  = in_rdy;
  assign ip_rewrite_wr_out_noc0_vrtoc_val = (state_q inside {ST_ACK_HDR, ST_ACK_BODY});
  assign wr_table_val                     = (state_q == ST_WR_TABLE);

  always_comb begin
    state_d      = state_q;
    init_done_d  = 1'b1;
    hdr_ld       = 1'b0;
    cfg_ld       = 1'b0;
    drain_dec    = 1'b0;
    ack_body_sel = 1'b0;
    ack_done     = 1'b0;
    case (state_q)
      ST_READY: begin
        if (in_fire) begin
          hdr_ld  = 1'b1;
          state_d = hdr_len_zero ? ST_ACK_HDR : ST_CFG;
        end
      end
      ST_CFG: begin
        if (in_fire) begin
          cfg_ld = 1'b1;
          if (cfg_ok)               state_d = ST_WR_TABLE;
          else if (!flits_left_one) state_d = ST_DRAIN;
          else                      state_d = ST_ACK_HDR;
        end
      end
      ST_WR_TABLE: begin
        if (wr_table_rdy) begin
          state_d = flits_left_zero ? ST_ACK_HDR : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (in_fire) begin
          drain_dec = 1'b1;
          if (flits_left_one) state_d = ST_ACK_HDR;
        end
      end
      ST_ACK_HDR: begin
        if (noc0_vrtoc_ip_rewrite_wr_out_rdy) state_d = ST_ACK_BODY;
      end
      ST_ACK_BODY: begin
        ack_body_sel = 1'b1;
        if (noc0_vrtoc_ip_rewrite_wr_out_rdy) begin
          ack_done = 1'b1;
          state_d  = ST_READY;
        end
      end
      default: state_d = ST_READY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_READY;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_done_q <= init_done_d;
    end
  end

  ip_rewrite_table_wr_datap #(
    .NOC_DATA_W  (NOC_DATA_W),
    .TABLE_DEPTH (TABLE_DEPTH),
    .INDEX_W     (INDEX_W),
    .SRC_X       (SRC_X),
    .SRC_Y       (SRC_Y)
  ) u_datap (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_data         (noc0_ctovr_ip_rewrite_wr_in_data),
    .hdr_ld          (hdr_ld),
    .cfg_ld          (cfg_ld),
    .drain_dec       (drain_dec),
    .ack_body_sel    (ack_body_sel),
    .ack_done        (ack_done),
    .hdr_len_zero    (hdr_len_zero),
    .cfg_ok          (cfg_ok),
    .flits_left_one  (flits_left_one),
    .flits_left_zero (flits_left_zero),
    .wr_table_index  (wr_table_index),
    .wr_table_entry  (wr_table_entry),
    .out_data        (ip_rewrite_wr_out_noc0_vrtoc_data),
    .wr_done_cnt     (wr_done_cnt)
  );

endmodule
